cfu_simd_mac_pipe: RTL
======================

// Module: cfu_simd_mac_pipe
// PURPOSE
//   Next-generation CPU custom-function unit for int8 conv/FC inner loops.
//   Computes a 4-lane signed-int8 dot product with a programmable input offset.
//   Adds the result into one of NUM_ACC independent accumulators.
//   Two-stage pipeline (multiply/reduce, accumulate) sustains one command per cycle.
//   Sits on the CPU CFU cmd/rsp bus in place of the single-accumulator, single-cycle unit.
// PARAMETERS
//   NUM_ACC   4   number of accumulators; power of two, 1..16
//   ACC_W     32  accumulator width, signed, 20..32; sign-extended to 32 on rsp
//   OFFSET_W  9   input-offset register width, signed
// PORTS
//   clk                      in   1   clock
//   reset                    in   1   asynchronous, active-low reset
//   cmd_valid                in   1   command strobe
//   cmd_ready                out  1   unit can accept a command this cycle
//   cmd_payload_function_id  in   10  [2:0] opcode, [6:3] accumulator select (low log2(NUM_ACC) bits used)
//   cmd_payload_inputs_0     in   32  4 x int8 activations, lane k = bits [8k+7:8k]
//   cmd_payload_inputs_1     in   32  4 x int8 weights, same lane order
//   rsp_valid                out  1   response available
//   rsp_ready                in   1   CPU takes response
//   rsp_payload_outputs_0    out  32  response data
// BEHAVIOUR
//   - Reset (async assert, clocked release): all acc=0, offset=0, s1_valid=0, rsp_valid=0, rsp_payload=0.
//     Reset mid-operation discards in-flight commands; no response is produced for them.
//   - Accept: cmd_valid & cmd_ready. cmd_ready = ~s1_valid | adv2, where adv2 = ~rsp_valid | rsp_ready.
//   - S1 (accept edge): registers opcode, sel and psum = sum_k (sext(in0[k]) + offset) * sext(in1[k]).
//     Each term is 18-bit signed; psum is 20-bit signed. SETOFF writes offset at this edge.
//     A command accepted on the next cycle uses the new offset.
//   - S2 (edge where s1_valid & adv2): performs the accumulator update and loads rsp_payload.
//     rsp_valid asserts 2 cycles after accept. Responses return in command order.
//   - No read-after-write hazard: accumulator read and write both happen in S2.
//     Back-to-back MACs to the same accumulator chain correctly.
//   - rsp_payload is held stable while rsp_valid & ~rsp_ready.
//     With S1 also full, cmd_ready=0 (max 2 in flight).
//   - Opcodes (state change happens at S2 unless noted):
//     0 MAC    : acc[sel] += psum; rsp = new acc[sel]
//     1 CLR    : acc[sel] = 0; rsp = 0
//     2 SETOFF : offset = in0[OFFSET_W-1:0] (at S1); rsp = 0
//     3 RD     : rsp = acc[sel]; no change
//     4 CLRALL : every acc = 0; rsp = 0
//     5 MACNEW : acc[sel] = psum (load, not add); rsp = psum
//     6 RDSAT  : see CONFIGURATION
//     7        : no state change; rsp = 0
//   - Arithmetic: acc + sext(psum) is computed at ACC_W+1 bits, then wraps modulo 2^ACC_W.
//     Saturation applies instead when enabled (see CONFIGURATION).
//   - sel >= NUM_ACC: only the low log2(NUM_ACC) bits are used, so the index aliases.
// CONFIGURATION
//   CFU_ACC_SAT_EN defined:
//     - MAC/MACNEW clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//     - Each clamp sets sticky bit sat[sel].
//     - RDSAT: rsp = {zero-pad, sat[NUM_ACC-1:0]}; clears all sat bits at S2.
//     - CLR/CLRALL also clear the corresponding sat bits.
//   CFU_ACC_SAT_EN undefined:
//     - Modulo wrap; no sat register; opcode 6 behaves as opcode 7.
// TESTING
//   1 SETOFF 128; MAC sel0 in0=0x01020304 in1=0x01010101
//     -> rsp 522 (129+130+131+132), rsp_valid 2 cycles after accept
//   2 MAC sel0 and MAC sel1 back-to-back, rsp_ready=1
//     -> one rsp per cycle, in order, each acc independent; cmd_ready stays 1
//   3 rsp_ready=0 for 5 cycles with 3 cmds offered
//     -> 2 accepted, cmd_ready=0, payload stable; third accepted after rsp_ready rises
//   4 ACC_W=20, offset 0, 9 x MAC sel0 in0=in1=0x7F7F7F7F (psum 64516)
//     -> SAT_EN: 524287, RDSAT=0x1; no SAT: -467932
//   5 reset low with 2 cmds in flight
//     -> rsp_valid=0 immediately; after release, RD any sel -> 0, offset 0
//   6 MAC sel2, CLRALL, RD sel2 -> 0; MACNEW sel3 in0=0xFF in1=0x02, offset 0 -> rsp -2

Source files
------------

// File: rtl/cfu_simd_mac_pipe.sv
// ---------------------------------------------------------------------------
// cfu_simd_mac_pipe
//
// CPU custom-function unit for int8 convolution / fully-connected inner loops.
// Each command computes a 4-lane signed-int8 dot product. Every activation is
// first biased by a programmable signed input offset. The dot product is then
// added into (or loaded into) one of NUM_ACC independent accumulators.
//
// The unit is a two-stage pipeline and sustains one command per cycle:
//   S1 (accept edge) : captures opcode, accumulator select and the partial sum.
//                      SETOFF updates the offset here, so the very next
//                      accepted command already uses the new offset.
//   S2 (drain edge)  : reads and writes the accumulator and loads the response.
//                      Both the read and the write happen in S2, so
//                      back-to-back commands to one accumulator chain without
//                      a hazard.
//
// Ports
//   clk                      in   1   clock
//   reset                    in   1   asynchronous active-low reset
//   cmd_valid                in   1   command strobe
//   cmd_ready                out  1   a command can be accepted this cycle
//   cmd_payload_function_id  in  10   [2:0] opcode, [6:3] accumulator select
//   cmd_payload_inputs_0     in  32   4 x int8 activations, lane k = [8k+7:8k]
//   cmd_payload_inputs_1     in  32   4 x int8 weights, same lane order
//   rsp_valid                out  1   response available
//   rsp_ready                in   1   CPU takes the response
//   rsp_payload_outputs_0    out 32   response data (accumulator sign-extended)
//
// Opcodes: 0 MAC, 1 CLR, 2 SETOFF, 3 RD, 4 CLRALL, 5 MACNEW, 6 RDSAT, 7 NOP.
//
// Build option
//   CFU_ACC_SAT_EN : when defined, MAC/MACNEW saturate instead of wrapping.
//                    Each clamp sets a sticky per-accumulator sat bit. RDSAT
//                    reads all sat bits and clears them. Without the macro,
//                    results wrap modulo 2^ACC_W and opcode 6 acts as a NOP.
// ---------------------------------------------------------------------------
module cfu_simd_mac_pipe #(
    parameter int NUM_ACC  = 4,   // power of two, 1..16
    parameter int ACC_W    = 32,  // signed accumulator width, 20..32
    parameter int OFFSET_W = 9    // signed input-offset width
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    // Lane sum must hold int8 + offset without overflow.
    localparam int LS_W  = ((OFFSET_W > 8) ? OFFSET_W : 8) + 1;
    localparam int PR_W  = LS_W + 8;      // one lane product
    localparam int PS_W  = PR_W + 2;      // sum of four lane products
    localparam int SUM_W = ACC_W + 1;     // accumulator add with carry/sign

    localparam logic [2:0] OP_MAC    = 3'd0;
    localparam logic [2:0] OP_CLR    = 3'd1;
    localparam logic [2:0] OP_SETOFF = 3'd2;
    localparam logic [2:0] OP_RD     = 3'd3;
    localparam logic [2:0] OP_CLRALL = 3'd4;
    localparam logic [2:0] OP_MACNEW = 3'd5;
    localparam logic [2:0] OP_RDSAT  = 3'd6;

`ifdef CFU_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Clamp a one-bit-wider sum into the accumulator range.
    function automatic logic signed [ACC_W-1:0] clamp_acc(input logic signed [SUM_W-1:0] v);
        if (v[ACC_W] != v[ACC_W-1]) begin
            clamp_acc = v[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            clamp_acc = v[ACC_W-1:0];
        end
    endfunction

    // True when the wide sum does not fit in ACC_W bits.
    function automatic logic sum_overflows(input logic signed [SUM_W-1:0] v);
        sum_overflows = (v[ACC_W] != v[ACC_W-1]);
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [OFFSET_W-1:0] offset_r;
    logic                       s1_valid_r;
    logic [2:0]                 s1_op_r;
    logic [SEL_W-1:0]           s1_sel_r;
    logic signed [PS_W-1:0]     s1_psum_r;
    logic signed [ACC_W-1:0]    acc_r [NUM_ACC];
    logic                       rsp_valid_r;
    logic [31:0]                rsp_payload_r;
`ifdef CFU_ACC_SAT_EN
    logic [NUM_ACC-1:0]         sat_r;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic             adv2_s;
    logic             fire2_s;
    logic             accept_s;
    logic [2:0]       op_in_s;
    logic [SEL_W-1:0] sel_in_s;
    logic             unused_fid_s;

    // S2 can drain whenever the response slot is empty or being taken.
    assign adv2_s    = ~rsp_valid_r | rsp_ready;
    assign fire2_s   = s1_valid_r & adv2_s;
    assign cmd_ready = ~s1_valid_r | adv2_s;
    assign accept_s  = cmd_valid & cmd_ready;

    assign op_in_s  = cmd_payload_function_id[2:0];
    // Only the low select bits are used, so larger selects alias.
    assign sel_in_s = (NUM_ACC == 1) ? {SEL_W{1'b0}} : cmd_payload_function_id[3 +: SEL_W];
    assign unused_fid_s = ^cmd_payload_function_id[9:3];

    assign rsp_valid             = rsp_valid_r;
    assign rsp_payload_outputs_0 = rsp_payload_r;

    // ------------------------------------------------------------------
    // S1 datapath: 4-lane (act + offset) * weight reduction
    // ------------------------------------------------------------------
    logic signed [7:0]      act_s  [4];
    logic signed [7:0]      wgt_s  [4];
    logic signed [LS_W-1:0] lane_s [4];
    logic signed [PR_W-1:0] prod_s [4];
    logic signed [PS_W-1:0] psum_s;

    // Dot product of the offset-biased activations with the weights.
    always_comb begin
        psum_s = {PS_W{1'b0}};
        for (int k = 0; k < 4; k++) begin
            act_s[k]  = cmd_payload_inputs_0[8*k +: 8];
            wgt_s[k]  = cmd_payload_inputs_1[8*k +: 8];
            lane_s[k] = LS_W'(act_s[k]) + LS_W'(offset_r);
            prod_s[k] = PR_W'(lane_s[k]) * PR_W'(wgt_s[k]);
            psum_s    = psum_s + PS_W'(prod_s[k]);
        end
    end

    // S1 pipeline register: filled on accept, emptied when S2 drains it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'd0;
            s1_sel_r   <= {SEL_W{1'b0}};
            s1_psum_r  <= {PS_W{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= op_in_s;
            s1_sel_r   <= sel_in_s;
            s1_psum_r  <= psum_s;
        end else if (adv2_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Input offset: written at the accept edge so the next command sees it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            offset_r <= {OFFSET_W{1'b0}};
        end else if (accept_s && (op_in_s == OP_SETOFF)) begin
            offset_r <= cmd_payload_inputs_0[OFFSET_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // S2 datapath: accumulator update and response formation
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_cur_s;
    logic signed [SUM_W-1:0] psum_ext_s;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [ACC_W-1:0] acc_new_s;
    logic                    sat_hit_s;
    logic [31:0]             rsp_next_s;

    // New accumulator value (add or load), then wrap or clamp.
    always_comb begin
        acc_cur_s  = acc_r[s1_sel_r];
        psum_ext_s = SUM_W'(s1_psum_r);
        if (s1_op_r == OP_MACNEW) begin
            sum_s = psum_ext_s;
        end else begin
            sum_s = SUM_W'(acc_cur_s) + psum_ext_s;
        end
`ifdef CFU_ACC_SAT_EN
        acc_new_s = clamp_acc(sum_s);
        sat_hit_s = sum_overflows(sum_s);
`else
        acc_new_s = sum_s[ACC_W-1:0];
        sat_hit_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
`endif
    end

    // Response data selected by the S2 opcode, sign-extended to 32 bits.
    always_comb begin
        rsp_next_s = 32'd0;
        case (s1_op_r)
            OP_MAC:    rsp_next_s = 32'(acc_new_s);
            OP_MACNEW: rsp_next_s = 32'(acc_new_s);
            OP_RD:     rsp_next_s = 32'(acc_cur_s);
`ifdef CFU_ACC_SAT_EN
            OP_RDSAT:  rsp_next_s = 32'(sat_r);
`endif
            default:   rsp_next_s = 32'd0;
        endcase
    end

    // Accumulator bank: read-modify-write entirely inside S2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else if (fire2_s) begin
            case (s1_op_r)
                OP_MAC:    acc_r[s1_sel_r] <= acc_new_s;
                OP_MACNEW: acc_r[s1_sel_r] <= acc_new_s;
                OP_CLR:    acc_r[s1_sel_r] <= {ACC_W{1'b0}};
                OP_CLRALL: begin
                    for (int i = 0; i < NUM_ACC; i++) begin
                        acc_r[i] <= {ACC_W{1'b0}};
                    end
                end
                default:   ;
            endcase
        end
    end

`ifdef CFU_ACC_SAT_EN
    // Sticky saturation flags: set on clamp, cleared by CLR/CLRALL/RDSAT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_r <= {NUM_ACC{1'b0}};
        end else if (fire2_s) begin
            case (s1_op_r)
                OP_MAC, OP_MACNEW: begin
                    if (sat_hit_s) begin
                        sat_r[s1_sel_r] <= 1'b1;
                    end
                end
                OP_CLR:    sat_r[s1_sel_r] <= 1'b0;
                OP_CLRALL: sat_r <= {NUM_ACC{1'b0}};
                OP_RDSAT:  sat_r <= {NUM_ACC{1'b0}};
                default:   ;
            endcase
        end
    end
`else
    logic unused_sat_s;
    assign unused_sat_s = sat_hit_s;
`endif

    // Response register: loaded when S2 drains, held while the CPU stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r   <= 1'b0;
            rsp_payload_r <= 32'd0;
        end else if (fire2_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_payload_r <= rsp_next_s;
        end else if (rsp_ready) begin
            rsp_valid_r   <= 1'b0;
        end
    end

endmodule
